main_controller_fsm: RTL and testbench

// Multicycle MIPS main control unit: sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath enables. Sits directly upstream of alu_controller: its alu_op output feeds
// alu_controller.alu_op, and instr[5:0] goes to fnctn. One FSM step per clock.

---
 rtl/main_controller_fsm_pkg.sv | 54 +++++
 rtl/main_controller_fsm_decode.sv | 74 +++++++
 rtl/main_controller_fsm.sv | 109 ++++++++++
 tb/tb_main_controller_fsm.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/main_controller_fsm_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, ALU-op codes,
// FSM states and the packed datapath control word.
package main_controller_fsm_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_FUNCT = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/main_controller_fsm_decode.sv
// Combinational state -> control-word decoder for the main controller.
// With MEM_WAIT_EN, FETCH gates ir_write/pc_write on mem_ready.
module main_controller_fsm_decode
  import main_controller_fsm_pkg::*;
(
  input  state_t state,
  input  logic   ori_sel,
`ifdef MEM_WAIT_EN
  input  logic   mem_ready,
`endif
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
`ifdef MEM_WAIT_EN
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
`else
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
`endif
      end
      S_DECODE:   ctrl.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        ctrl.alu_op    = ori_sel ? ALUOP_OR : ALUOP_ADD;
      end
      S_I_WB:     ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = 2'b10;
      end
      S_ILLEGAL:  ctrl.illegal_op = 1'b1;
      default:    ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_controller_fsm.sv
// Multicycle MIPS main control FSM: state register, next-state logic and I-type flags.
// Optional `MEM_WAIT_EN adds mem_ready and stalls FETCH/MEM_READ/MEM_WRITE until it is high.
module main_controller_fsm
  import main_controller_fsm_pkg::*;
#(
  parameter int unsigned OP_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
`ifdef MEM_WAIT_EN
  input  logic            mem_ready,
`endif
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            mem_to_reg,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic            illegal_op
);

  state_t state_q, state_d;
  logic   ori_q, ori_d;
  logic   sw_q, sw_d;
  logic   mem_go;
  ctrl_t  ctrl;

`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  assign mem_go = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ori_d   = ori_q;
    sw_d    = sw_q;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: if (mem_go) state_d = S_DECODE;
      S_DECODE: begin
        // opcode is only trusted here, so lw/sw and addi/ori choices are latched for later states
        ori_d = (opcode == OP_ORI);
        sw_d  = (opcode == OP_SW);
        case (opcode)
          OP_LW, OP_SW:     state_d = S_MEM_ADDR;
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_BEQ:           state_d = S_BRANCH;
          OP_J:             state_d = S_JUMP;
          OP_ADDI, OP_ORI:  state_d = S_EXEC_I;
          default:          state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  state_d = sw_q ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_go) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_go) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_EXEC_I:    state_d = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL:
                   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      ori_q   <= 1'b0;
      sw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ori_q   <= ori_d;
      sw_q    <= sw_d;
    end
  end

  main_controller_fsm_decode u_decode (
    .state     (state_q),
    .ori_sel   (ori_q),
`ifdef MEM_WAIT_EN
    .mem_ready (mem_ready),
`endif
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;

endmodule

// File: tb/tb_main_controller_fsm.sv
// Directed bench for main_controller_fsm: walks every instruction class cycle by cycle
// and compares the full control word against hand-written per-state values.
module tb_main_controller_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  main_controller_fsm #(.OP_W(6)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
`ifdef MEM_WAIT_EN
    .mem_ready     (mem_ready),
`endif
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .illegal_op    (illegal_op)
  );

  // Bit order: pcw pcc iod mr mw irw m2r rd rw asa asb[2] aop[2] psrc[2] ill
  logic [16:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  function automatic logic [16:0] cw(input logic pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa,
                                     input logic [1:0] asb, aop, psrc, input logic ill);
    return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
  endfunction

  //                          pcw pcc iod mr mw irw m2r rd rw asa asb    aop    psrc   ill
  localparam logic [16:0] W_ZERO   = '0;
  localparam logic [16:0] W_FETCH  = cw(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_DECODE = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_MADDR  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_MREAD  = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_MWB    = cw(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_MWRITE = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_EXR    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b11, 2'b00, 0);
  localparam logic [16:0] W_RWB    = cw(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_EXADD  = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_EXOR   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 0);
  localparam logic [16:0] W_IWB    = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0);
  localparam logic [16:0] W_BR     = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0);
  localparam logic [16:0] W_JMP    = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0);
  localparam logic [16:0] W_ILL    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1);
`ifdef MEM_WAIT_EN
  localparam logic [16:0] W_FWAIT  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0);
`endif

  task automatic step(input string tag, input logic [16:0] exp);
    @(negedge clk);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    opcode = 6'b000000;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (2) @(posedge clk);
    step("reset", W_ZERO);
    rst_n = 1'b1;
    step("rst_fetch", W_FETCH);

    // lw: 5 cycles; opcode is scrambled after DECODE to show it is ignored
    opcode = 6'b100011;
    step("lw_decode", W_DECODE);
    step("lw_maddr",  W_MADDR);
    opcode = 6'b101011;
    step("lw_mread",  W_MREAD);
    step("lw_mwb",    W_MWB);
    step("lw_fetch",  W_FETCH);

    // sw: 4 cycles
    opcode = 6'b101011;
    step("sw_decode", W_DECODE);
    step("sw_maddr",  W_MADDR);
    opcode = 6'b100011;
    step("sw_mwrite", W_MWRITE);
    step("sw_fetch",  W_FETCH);

    // R-type: 4 cycles
    opcode = 6'b000000;
    step("r_decode", W_DECODE);
    step("r_exec",   W_EXR);
    step("r_wb",     W_RWB);
    step("r_fetch",  W_FETCH);

    // ori then addi: alu_op 10 vs 00
    opcode = 6'b001101;
    step("ori_decode", W_DECODE);
    step("ori_exec",   W_EXOR);
    opcode = 6'b001000;
    step("ori_wb",     W_IWB);
    step("ori_fetch",  W_FETCH);
    step("addi_decode", W_DECODE);
    step("addi_exec",   W_EXADD);
    step("addi_wb",     W_IWB);
    step("addi_fetch",  W_FETCH);

    // beq, j, illegal: 3 cycles each
    opcode = 6'b000100;
    step("beq_decode", W_DECODE);
    step("beq_branch", W_BR);
    step("beq_fetch",  W_FETCH);
    opcode = 6'b000010;
    step("j_decode", W_DECODE);
    step("j_jump",   W_JMP);
    step("j_fetch",  W_FETCH);
    opcode = 6'b111111;
    step("ill_decode", W_DECODE);
    step("ill_pulse",  W_ILL);
    step("ill_fetch",  W_FETCH);

    // Reset during MEM_READ of lw: no MEM_WB write may follow
    opcode = 6'b100011;
    step("abort_decode", W_DECODE);
    step("abort_maddr",  W_MADDR);
    step("abort_mread",  W_MREAD);
    rst_n = 1'b0;
    step("abort_reset1", W_ZERO);
    step("abort_reset2", W_ZERO);
    rst_n = 1'b1;
    step("abort_fetch",  W_FETCH);

`ifdef MEM_WAIT_EN
    // FETCH stalled 3 cycles: pc_write/ir_write only in the ready cycle
    opcode = 6'b000010;
    step("w_decode", W_DECODE);
    step("w_jump",   W_JMP);
    mem_ready = 1'b0;
    step("w_fwait1", W_FWAIT);
    step("w_fwait2", W_FWAIT);
    step("w_fwait3", W_FWAIT);
    mem_ready = 1'b1;
    #1;
    checks++;
    assert (obs === W_FETCH) else begin
      errors++;
      $error("FAIL w_fready: observed %b expected %b", obs, W_FETCH);
    end
    step("w_decode2", W_DECODE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
